// File: rtl/sat_ctrl_pkg.sv
// Shared types and constants for the clause BCP controller: FSM states, result codes,
// freelit count encoding and the classification rule.
package sat_ctrl_pkg;

    localparam int unsigned VAR_W = 3;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSettle,
        StEval,
        StDrive,
        StCapture,
        StResult
    } state_e;

    localparam logic [1:0] RES_UNDEF    = 2'd0;
    localparam logic [1:0] RES_SAT      = 2'd1;
    localparam logic [1:0] RES_UNIT     = 2'd2;
    localparam logic [1:0] RES_CONFLICT = 2'd3;

    localparam logic [1:0] FLC_ZERO = 2'd0;
    localparam logic [1:0] FLC_ONE  = 2'd1;
    localparam logic [1:0] FLC_TWO  = 2'd2;
    localparam logic [1:0] FLC_MANY = 2'd3;

    // Satisfied wins over any free-literal count.
    function automatic logic [1:0] classify(input logic sat, input logic [1:0] flc);
        logic [1:0] code;
        code = RES_UNDEF;
        if (sat) begin
            code = RES_SAT;
        end else begin
            unique case (flc)
                FLC_ZERO:           code = RES_CONFLICT;
                FLC_ONE:            code = RES_UNIT;
                FLC_TWO, FLC_MANY:  code = RES_UNDEF;
                default:            code = RES_UNDEF;
            endcase
        end
        return code;
    endfunction

endpackage

// File: rtl/clause_bcp_ctrl_if.sv
// Base handshake and lit-row signals of one clause controller.
interface clause_bcp_ctrl_if import sat_ctrl_pkg::*; #(
    parameter int unsigned NUM_LITS = 2
);
    localparam int unsigned VW = NUM_LITS * VAR_W;

    logic                start_valid_i;
    logic                start_ready_o;
    logic [VW-1:0]       var_value_i;
    logic                lit_wr_o;
    logic [VW-1:0]       lit_var_value_o;
    logic [VW-1:0]       lit_var_value_i;
    logic [1:0]          lit_freelitcnt_i;
    logic                lit_clausesat_i;
    logic                lit_imp_drv_o;
    logic                lit_cclause_drv_o;
    logic [NUM_LITS-1:0] lit_cclause_i;
    logic                res_valid_o;
    logic                res_ready_i;
    logic [1:0]          res_code_o;
    logic [VW-1:0]       res_var_value_o;
    logic [NUM_LITS-1:0] res_cclause_o;
    logic                busy_o;
    logic [15:0]         conf_cnt_o;

    modport master (
        input  start_valid_i, var_value_i, lit_var_value_i, lit_freelitcnt_i,
        input  lit_clausesat_i, lit_cclause_i, res_ready_i,
        output start_ready_o, lit_wr_o, lit_var_value_o, lit_imp_drv_o, lit_cclause_drv_o,
        output res_valid_o, res_code_o, res_var_value_o, res_cclause_o, busy_o, conf_cnt_o
    );

    modport slave (
        output start_valid_i, var_value_i, lit_var_value_i, lit_freelitcnt_i,
        output lit_clausesat_i, lit_cclause_i, res_ready_i,
        input  start_ready_o, lit_wr_o, lit_var_value_o, lit_imp_drv_o, lit_cclause_drv_o,
        input  res_valid_o, res_code_o, res_var_value_o, res_cclause_o, busy_o, conf_cnt_o
    );

endinterface

// File: rtl/settle_timer.sv
// 4-bit down-counter timing the freelit chain settle window; done flags the last cycle.
module settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       done
);
    logic [3:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign done = (cnt_q == 4'd1);

endmodule

// File: rtl/clause_bcp_ctrl.sv
// Clause row sequencer: write values, wait for settle, classify, optionally drive
// implication/conflict and capture, then hand the result to the base.
module clause_bcp_ctrl import sat_ctrl_pkg::*; #(
    parameter int unsigned NUM_LITS      = 2,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input logic               clk,
    input logic               rst,
    clause_bcp_ctrl_if.master bus
);
    localparam int unsigned VW = NUM_LITS * VAR_W;

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..15");
    end

    state_e              state_q, state_d;
    logic [VW-1:0]       req_q;
    logic [VW-1:0]       res_var_q;
    logic [NUM_LITS-1:0] res_cc_q;
    logic [1:0]          code_q;
    logic [15:0]         conf_cnt_q;
    logic [1:0]          cls;
    logic                tmr_load, tmr_en, tmr_done;

    settle_timer u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (4'(SETTLE_CYCLES)),
        .en       (tmr_en),
        .done     (tmr_done)
    );

    assign cls = classify(bus.lit_clausesat_i, bus.lit_freelitcnt_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        unique case (state_q)
            StIdle:    if (bus.start_valid_i) state_d = StLoad;
            StLoad: begin
                tmr_load = 1'b1;
                state_d  = StSettle;
            end
            StSettle: begin
                tmr_en = 1'b1;
                if (tmr_done) state_d = StEval;
            end
            StEval:    state_d = (cls == RES_UNIT || cls == RES_CONFLICT) ? StDrive : StResult;
            StDrive:   state_d = StCapture;
            StCapture: state_d = StResult;
            StResult:  if (bus.res_ready_i) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Row inputs are only looked at in EVAL and CAPTURE.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q     <= '0;
            code_q    <= RES_UNDEF;
            res_var_q <= '0;
            res_cc_q  <= '0;
        end else begin
            if (state_q == StIdle && bus.start_valid_i) begin
                req_q <= bus.var_value_i;
            end
            if (state_q == StEval) begin
                code_q    <= cls;
                res_var_q <= req_q;
                res_cc_q  <= '0;
            end
            if (state_q == StCapture) begin
                if (code_q == RES_UNIT) begin
                    res_var_q <= bus.lit_var_value_i;
                end else begin
                    res_cc_q <= bus.lit_cclause_i;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conf_cnt_q <= 16'd0;
        end else if (state_q == StResult && bus.res_ready_i && code_q == RES_CONFLICT &&
                     conf_cnt_q != 16'hFFFF) begin
            conf_cnt_q <= conf_cnt_q + 16'd1;
        end
    end

    assign bus.start_ready_o     = (state_q == StIdle);
    assign bus.busy_o            = (state_q != StIdle);
    assign bus.lit_wr_o          = (state_q == StLoad);
    assign bus.lit_var_value_o   = req_q;
    assign bus.lit_imp_drv_o     = (state_q == StDrive) && (code_q == RES_UNIT);
    assign bus.lit_cclause_drv_o = (state_q == StDrive) && (code_q == RES_CONFLICT);
    assign bus.res_valid_o       = (state_q == StResult);
    assign bus.res_code_o        = code_q;
    assign bus.res_var_value_o   = res_var_q;
    assign bus.res_cclause_o     = res_cc_q;
    assign bus.conf_cnt_o        = conf_cnt_q;

endmodule

// File: tb/tb_clause_bcp_ctrl.sv
// Self-checking bench for clause_bcp_ctrl with a cycle-level reference of the expected
// request timeline and result payload.
module tb_clause_bcp_ctrl;

    localparam int S = 2;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    clause_bcp_ctrl_if #(.NUM_LITS(2)) bus ();

    clause_bcp_ctrl #(.NUM_LITS(2), .SETTLE_CYCLES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // One full request; rwait = cycles of backpressure, keep = hold start_valid afterwards.
    task automatic run_req(input logic [5:0] val, input bit sat, input logic [1:0] flc,
                           input logic [5:0] vv, input logic [1:0] cc, input int rwait,
                           input bit keep, input string tag);
        logic [1:0] code;
        logic [5:0] ev;
        logic [1:0] ecc;
        int         lat;
        int         ch;
        code = sat ? 2'd1 : (flc == 2'd0 ? 2'd3 : (flc == 2'd1 ? 2'd2 : 2'd0));
        lat  = (code == 2'd2 || code == 2'd3) ? 5 + S : 3 + S;
        ch   = lat + rwait;
        ev   = (code == 2'd2) ? vv : val;
        ecc  = (code == 2'd3) ? cc : 2'd0;
        for (int c = 0; c <= ch; c++) begin
            bus.start_valid_i    = (c == 0) || keep;
            bus.var_value_i      = (c == 0) ? val : 6'($urandom);
            bus.lit_clausesat_i  = (c == 2 + S) ? sat : 1'($urandom);
            bus.lit_freelitcnt_i = (c == 2 + S) ? flc : 2'($urandom);
            bus.lit_var_value_i  = (c == 4 + S) ? vv : 6'($urandom);
            bus.lit_cclause_i    = (c == 4 + S) ? cc : 2'($urandom);
            bus.res_ready_i      = (c >= ch) || (c < lat && 1'($urandom));
            checks++;
            if (bus.start_ready_o !== (c == 0)) begin
                errors++;
                $display("FAIL %s start_ready c=%0d got=%b exp=%b", tag, c, bus.start_ready_o,
                         c == 0);
            end
            checks++;
            if (bus.busy_o !== (c != 0)) begin
                errors++;
                $display("FAIL %s busy c=%0d got=%b exp=%b", tag, c, bus.busy_o, c != 0);
            end
            checks++;
            if (bus.lit_wr_o !== (c == 1)) begin
                errors++;
                $display("FAIL %s lit_wr c=%0d got=%b exp=%b", tag, c, bus.lit_wr_o, c == 1);
            end
            checks++;
            if (bus.lit_imp_drv_o !== (c == 3 + S && code == 2'd2)) begin
                errors++;
                $display("FAIL %s imp_drv c=%0d got=%b", tag, c, bus.lit_imp_drv_o);
            end
            checks++;
            if (bus.lit_cclause_drv_o !== (c == 3 + S && code == 2'd3)) begin
                errors++;
                $display("FAIL %s cclause_drv c=%0d got=%b", tag, c, bus.lit_cclause_drv_o);
            end
            checks++;
            if (bus.res_valid_o !== (c >= lat)) begin
                errors++;
                $display("FAIL %s res_valid c=%0d got=%b exp=%b", tag, c, bus.res_valid_o,
                         c >= lat);
            end
            checks++;
            if (bus.conf_cnt_o !== 16'(exp_cnt)) begin
                errors++;
                $display("FAIL %s conf_cnt c=%0d got=%h exp=%h", tag, c, bus.conf_cnt_o,
                         16'(exp_cnt));
            end
            if (c >= 1) begin
                checks++;
                if (bus.lit_var_value_o !== val) begin
                    errors++;
                    $display("FAIL %s lit_var_value c=%0d got=%h exp=%h", tag, c,
                             bus.lit_var_value_o, val);
                end
            end
            if (c >= lat) begin
                checks++;
                if (bus.res_code_o !== code || bus.res_var_value_o !== ev ||
                    bus.res_cclause_o !== ecc) begin
                    errors++;
                    $display("FAIL %s result c=%0d got=%0d/%h/%b exp=%0d/%h/%b", tag, c,
                             bus.res_code_o, bus.res_var_value_o, bus.res_cclause_o,
                             code, ev, ecc);
                end
            end
            @(posedge clk);
            if (c == ch && code == 2'd3 && exp_cnt < 16'hFFFF) exp_cnt++;
            @(negedge clk);
        end
        bus.start_valid_i = keep;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (bus.start_ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.lit_wr_o !== 1'b0 ||
            bus.lit_var_value_o !== 6'd0 || bus.lit_imp_drv_o !== 1'b0 ||
            bus.lit_cclause_drv_o !== 1'b0 || bus.res_valid_o !== 1'b0 ||
            bus.res_code_o !== 2'd0 || bus.res_var_value_o !== 6'd0 ||
            bus.res_cclause_o !== 2'd0 || bus.conf_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL %s reset_outputs got rdy=%b busy=%b wr=%b lv=%h imp=%b cc=%b vld=%b code=%0d rv=%h rc=%b cnt=%h exp rdy=1 rest=0",
                     tag, bus.start_ready_o, bus.busy_o, bus.lit_wr_o, bus.lit_var_value_o,
                     bus.lit_imp_drv_o, bus.lit_cclause_drv_o, bus.res_valid_o,
                     bus.res_code_o, bus.res_var_value_o, bus.res_cclause_o, bus.conf_cnt_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_sat();
        run_req(6'h15, 1'b1, 2'd0, 6'h3F, 2'b11, 0, 1'b0, "sat");
    endtask

    task automatic test_unit();
        run_req(6'h11, 1'b0, 2'd1, 6'h2A, 2'b11, 0, 1'b0, "unit");
    endtask

    task automatic test_conflict();
        run_req(6'h07, 1'b0, 2'd0, 6'h33, 2'b10, 0, 1'b0, "conflict");
        checks++;
        if (bus.conf_cnt_o !== 16'd1) begin
            errors++;
            $display("FAIL conflict conf_cnt_after got=%h exp=0001", bus.conf_cnt_o);
        end
    endtask

    task automatic test_backpressure();
        run_req(6'h2C, 1'b0, 2'd1, 6'h19, 2'b01, 10, 1'b1, "bp_unit");
        run_req(6'h0B, 1'b0, 2'd3, 6'h21, 2'b10, 10, 1'b1, "bp_undef");
        run_req(6'h31, 1'b0, 2'd0, 6'h05, 2'b01, 0, 1'b0, "bp_next");
    endtask

    task automatic test_back_to_back();
        run_req(6'h01, 1'b1, 2'd2, 6'h00, 2'b00, 0, 1'b1, "b2b_sat");
        run_req(6'h02, 1'b0, 2'd2, 6'h00, 2'b00, 0, 1'b1, "b2b_undef");
        run_req(6'h03, 1'b0, 2'd0, 6'h00, 2'b11, 0, 1'b1, "b2b_conf");
        run_req(6'h04, 1'b0, 2'd1, 6'h3C, 2'b00, 0, 1'b0, "b2b_unit");
    endtask

    task automatic test_reset_midop();
        bus.lit_clausesat_i  = 1'b1;
        bus.start_valid_i    = 1'b1;
        bus.var_value_i      = 6'h2E;
        bus.res_ready_i      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_midop");
        rst = 1'b0;
        exp_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.res_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_midop aborted_result i=%0d got vld=%b busy=%b exp=0/0",
                         i, bus.res_valid_o, bus.busy_o);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_req(6'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom), 6'($urandom),
                    2'($urandom), $urandom_range(0, 3), (i != 23) && 1'($urandom), "random");
        end
    endtask

    task automatic test_saturation();
        force dut.conf_cnt_q = 16'hFFFE;
        #1;
        release dut.conf_cnt_q;
        exp_cnt = 16'hFFFE;
        for (int k = 0; k < 2; k++) begin
            run_req(6'($urandom), 1'b0, 2'd0, 6'($urandom), 2'($urandom), 0, 1'b0, "sat_cnt");
            checks++;
            if (bus.conf_cnt_o !== 16'hFFFF) begin
                errors++;
                $display("FAIL saturation conf_cnt k=%0d got=%h exp=ffff", k, bus.conf_cnt_o);
            end
        end
    endtask

    initial begin
        rst                  = 1'b1;
        bus.start_valid_i    = 1'b0;
        bus.var_value_i      = '0;
        bus.lit_var_value_i  = '0;
        bus.lit_freelitcnt_i = '0;
        bus.lit_clausesat_i  = 1'b0;
        bus.lit_cclause_i    = '0;
        bus.res_ready_i      = 1'b0;
        test_reset();
        test_sat();
        test_unit();
        test_conflict();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clause_bcp_ctrl.md
# clause_bcp_ctrl

Sequencer for one clause row of lit cells in a bin. It accepts a vector of variable values from the base, writes it into the row, waits for the freelit chain to settle, and classifies the clause as undetermined, satisfied, unit or conflicting. For a unit clause it fires the implication drive and captures the implied values. For a conflicting clause it fires the conflict-clause drive and captures the conflict literal mask. It reports the outcome to the base over a valid/ready handshake.

## Interface
- `NUM_LITS`, default 2: literals in the controlled row. Each literal carries a 3-bit variable field.
- `SETTLE_CYCLES`, default 2: wait cycles after a write before sampling row status. Legal range is 1 to 15.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `start_valid_i`, in, 1: request valid.
- `start_ready_o`, out, 1: controller can accept a request.
- `var_value_i`, in, `NUM_LITS*3`: variable values for the request.
- `lit_wr_o`, out, 1: write strobe to the row.
- `lit_var_value_o`, out, `NUM_LITS*3`: values written to the row.
- `lit_var_value_i`, in, `NUM_LITS*3`: values read back from the row.
- `lit_freelitcnt_i`, in, 2: free-literal count at the end of the row chain. Values 2 and 3 both mean "two or more".
- `lit_clausesat_i`, in, 1: the row is satisfied.
- `lit_imp_drv_o`, out, 1: implication drive strobe.
- `lit_cclause_drv_o`, out, 1: conflict-clause drive strobe.
- `lit_cclause_i`, in, `NUM_LITS`: conflict literal mask from the row.
- `res_valid_o`, out, 1: result valid.
- `res_ready_i`, in, 1: result consumed.
- `res_code_o`, out, 2: result code. 0 = UNDEF, 1 = SAT, 2 = UNIT, 3 = CONFLICT.
- `res_var_value_o`, out, `NUM_LITS*3`: result variable values.
- `res_cclause_o`, out, `NUM_LITS`: result conflict mask.
- `busy_o`, out, 1: controller is not in IDLE.
- `conf_cnt_o`, out, 16: saturating count of CONFLICT results.

## Operation
- States:
  - IDLE: `start_ready_o` = 1.
  - LOAD: `lit_wr_o` = 1.
  - SETTLE: counts `SETTLE_CYCLES` cycles.
  - EVAL: samples `lit_clausesat_i` and `lit_freelitcnt_i`.
  - DRIVE: for UNIT, `lit_imp_drv_o` = 1; for CONFLICT, `lit_cclause_drv_o` = 1.
  - CAPTURE: samples `lit_var_value_i` or `lit_cclause_i`.
  - RESULT: `res_valid_o` = 1.
- On `start_valid_i & start_ready_o`, `var_value_i` is registered and the FSM moves to LOAD.
- `lit_var_value_o` shows the registered value from LOAD until the next accept. It is 0 after reset.
- Classification in EVAL, with `lit_clausesat_i` taking priority:
  - `lit_clausesat_i` = 1 → SAT.
  - Otherwise freelitcnt = 0 → CONFLICT.
  - Otherwise freelitcnt = 1 → UNIT.
  - Otherwise (2 or 3) → UNDEF.
- SAT and UNDEF go from EVAL straight to RESULT. UNIT and CONFLICT go EVAL → DRIVE → CAPTURE → RESULT.
- Result payload:
  - UNIT: `res_var_value_o` is the value captured from `lit_var_value_i`.
  - All other codes: `res_var_value_o` is the registered request value.
  - CONFLICT: `res_cclause_o` is the captured `lit_cclause_i`; it is 0 for every other code.
- `res_*` outputs are held stable while `res_valid_o` = 1 and `res_ready_i` = 0.
- When `res_valid_o & res_ready_i`, the FSM returns to IDLE. A new request cannot be accepted in that same cycle.
- `conf_cnt_o` increments when a CONFLICT result is handed off, and saturates at 0xFFFF.
- Reset, including mid-operation:
  - Every output goes to 0, except `start_ready_o` = 1.
  - State returns to IDLE, the settle counter clears and `conf_cnt_o` clears.
  - Any in-flight request is discarded and no result is produced for it.

## Timing
- Cycle 0 is the accept cycle.
- LOAD is cycle 1.
- SETTLE spans cycles 2 to 1+S, where S = `SETTLE_CYCLES`.
- EVAL is cycle 2+S.
- SAT or UNDEF: `res_valid_o` first high in cycle 3+S.
- UNIT or CONFLICT: DRIVE in cycle 3+S, CAPTURE in cycle 4+S, `res_valid_o` first high in cycle 5+S.
- Every drive strobe (`lit_wr_o`, `lit_imp_drv_o`, `lit_cclause_drv_o`) is exactly one cycle wide. At most one strobe is high in any cycle.
- The row inputs are sampled only in EVAL and CAPTURE; all other cycles ignore them.
- All outputs are registered or decoded from state only; there is no combinational path from input to output.
- Minimum request spacing at S = 2 is 6 cycles for SAT/UNDEF and 8 cycles for UNIT/CONFLICT, given `res_ready_i` tied high.

## Structure
- Shared package `sat_ctrl_pkg` holds:
  - the state enum;
  - the result-code constants `RES_UNDEF`, `RES_SAT`, `RES_UNIT` and `RES_CONFLICT`;
  - `VAR_W` = 3;
  - the freelitcnt encoding constants.
- Sub-module `settle_timer` is a 4-bit down-counter with load and done outputs, instantiated once.

## Test plan
- SAT: accept with `lit_clausesat_i` = 1 and freelitcnt = 0, S = 2 → `res_valid_o` rises in cycle 5 with code 1; `res_var_value_o` equals the request; `res_cclause_o` = 0; no imp or cclause strobe.
- UNIT: freelitcnt = 1, clausesat = 0, `lit_var_value_i` = 0x2A → one `lit_imp_drv_o` pulse in cycle 5; result code 2 with value 0x2A in cycle 7.
- CONFLICT: freelitcnt = 0, clausesat = 0, `lit_cclause_i` = 2'b10 → `lit_cclause_drv_o` pulse in cycle 5; result code 3 with mask 2'b10; `conf_cnt_o` goes to 1 after the handoff.
- Backpressure: hold `res_ready_i` = 0 for 10 cycles → result held stable; `start_ready_o` stays 0 while `start_valid_i` = 1; after the handshake, the next accept happens no earlier than the following cycle.
- Reset mid-op: assert `rst` in SETTLE → the next cycle shows all outputs 0, `start_ready_o` = 1, `conf_cnt_o` = 0, and no `res_valid_o` for the aborted request.
- Saturation: preload the counter (force) to 0xFFFE, then run two CONFLICT requests → `conf_cnt_o` reads 0xFFFF after each.
